// File: rtl/countdown_chain.sv
// countdown_chain: multi-digit mixed-radix countdown register with
// run/pause/expire control. Digit i of every packed bus sits at [i*W +: W].

// One digit of the borrow chain: steps down by one, or reloads its wrap value
// when it is stepped at zero.
module countdown_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] wrap,
    input  logic [W-1:0] set,
    input  logic         step,
    output logic [W-1:0] nxt,
    output logic [W-1:0] clamp,
    output logic         zero
);
    assign zero  = (cur == '0);
    assign nxt   = !step ? cur : (zero ? wrap : cur - W'(1));
    // Out-of-range load values saturate at the digit's wrap value
    assign clamp = (set > wrap) ? wrap : set;
endmodule

module countdown_chain #(
    parameter int                  DIGITS = 4,
    parameter int                  W      = 4,
    parameter logic [DIGITS*W-1:0] WRAP   = 16'h5959
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIGITS*W-1:0] setting,
    input  logic                load,
    input  logic                start,
    input  logic                pause,
    input  logic                tick,
    output logic [DIGITS*W-1:0] running,
    output logic [1:0]          state,
    output logic                expired,
    output logic                done_pulse
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [DIGITS*W-1:0] ONE = (DIGITS*W)'(1);

    state_t              st_q, st_d;
    logic [DIGITS*W-1:0] cnt_d;
    logic [DIGITS*W-1:0] dec;
    logic [DIGITS*W-1:0] clamped;
    logic [DIGITS-1:0]   zero;
    logic [DIGITS-1:0]   borrow;
    logic                pulse_d;
    logic                all_zero;

    // Borrow chain: digit 0 always steps, digit i steps when every lower
    // digit was zero before the tick.
    assign borrow[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        countdown_digit #(.W(W)) u_dig (
            .cur   (running[g*W +: W]),
            .wrap  (WRAP[g*W +: W]),
            .set   (setting[g*W +: W]),
            .step  (borrow[g]),
            .nxt   (dec[g*W +: W]),
            .clamp (clamped[g*W +: W]),
            .zero  (zero[g])
        );
        if (g < DIGITS-1) begin : g_brw
            assign borrow[g+1] = borrow[g] & zero[g];
        end
    end

    assign all_zero = &zero;
    assign state    = st_q;

    // Next-state and datapath: a single action per cycle, in priority order
    // load > start > pause > tick. Expiry beats the wrap so zero never wraps.
    always_comb begin
        st_d    = st_q;
        cnt_d   = running;
        pulse_d = 1'b0;
        if (load) begin
            cnt_d = clamped;
            st_d  = IDLE;
        end else if (start && (st_q == IDLE || st_q == PAUSE)) begin
            if (all_zero) begin
                st_d    = DONE;
                pulse_d = 1'b1;
            end else begin
                st_d = RUN;
            end
        end else if (pause && st_q == RUN) begin
            st_d = PAUSE;
        end else if (tick && st_q == RUN) begin
            if (running == ONE) begin
                cnt_d   = '0;
                st_d    = DONE;
                pulse_d = 1'b1;
            end else begin
                cnt_d = dec;
            end
        end
    end

    // State, count and flags all registered together; reset drops any pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= IDLE;
            running    <= '0;
            expired    <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            st_q       <= st_d;
            running    <= cnt_d;
            expired    <= (st_d == DONE);
            done_pulse <= pulse_d;
        end
    end
endmodule

// File: tb/tb_countdown_chain.sv
// Bench for countdown_chain (default MM:SS configuration). The model keeps
// the count as a plain integer of seconds and converts to digits for checks.
module tb_countdown_chain;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] setting = '0;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
    logic [15:0] running;
    logic [1:0]  state;
    logic        expired, done_pulse;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;

    countdown_chain dut (
        .clk(clk), .reset(reset), .setting(setting), .load(load),
        .start(start), .pause(pause), .tick(tick), .running(running),
        .state(state), .expired(expired), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // Radix of each digit (wrap + 1), seconds units first
    function automatic int radix(input int i);
        case (i)
            0: return 10;
            1: return 6;
            2: return 10;
            default: return 6;
        endcase
    endfunction

    function automatic int to_n(input logic [15:0] v);
        int n = 0;
        int m = 1;
        for (int i = 0; i < 4; i++) begin
            int d = int'(v[i*4 +: 4]);
            if (d > radix(i) - 1) d = radix(i) - 1;
            n += d * m;
            m *= radix(i);
        end
        return n;
    endfunction

    function automatic logic [15:0] to_v(input int n);
        logic [15:0] v = '0;
        int r = n;
        for (int i = 0; i < 4; i++) begin
            v[i*4 +: 4] = 4'(r % radix(i));
            r = r / radix(i);
        end
        return v;
    endfunction

    // Model: 0=IDLE 1=RUN 2=PAUSE 3=DONE, count in seconds
    int mn = 0, ms = 0, mn_nx, ms_nx;
    bit mp = 1'b0, mp_nx;

    always_comb begin
        mn_nx = mn;
        ms_nx = ms;
        mp_nx = 1'b0;
        if (reset) begin
            mn_nx = 0;
            ms_nx = 0;
        end else if (load) begin
            mn_nx = to_n(setting);
            ms_nx = 0;
        end else if (start && (ms == 0 || ms == 2)) begin
            if (mn != 0) ms_nx = 1;
            else begin
                ms_nx = 3;
                mp_nx = 1'b1;
            end
        end else if (pause && ms == 1) begin
            ms_nx = 2;
        end else if (tick && ms == 1) begin
            mn_nx = mn - 1;
            if (mn_nx == 0) begin
                ms_nx = 3;
                mp_nx = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        mn    <= mn_nx;
        ms    <= ms_nx;
        mp    <= mp_nx;
        armed <= 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            vectors++;
            if (running !== to_v(mn) || state !== 2'(ms) ||
                expired !== (ms == 3) || done_pulse !== mp) begin
                miscompares++;
                $display("FAIL model t=%0t: got run=%h st=%0d exp=%b dp=%b, want run=%h st=%0d exp=%b dp=%b",
                         $time, running, state, expired, done_pulse,
                         to_v(mn), ms, (ms == 3), mp);
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One clock of stimulus; returns at the following negedge
    task automatic step(input bit r, input bit l, input bit s, input bit p,
                        input bit t, input logic [15:0] set);
        reset = r; load = l; start = s; pause = p; tick = t; setting = set;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0, 16'h0);
        lit("reset_run", running, 16'h0);
        lit("reset_state", 16'(state), 16'h0);

        // Reset mid-RUN
        step(0, 1, 0, 0, 0, 16'h0343);
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        lit("pre_reset", running, 16'h0342);
        step(1, 0, 0, 0, 1, 16'h0);
        lit("rst_run", running, 16'h0);
        lit("rst_flags", {13'h0, state, expired}, 16'h0);
        lit("rst_pulse", 16'(done_pulse), 16'h0);

        // Load clamp
        step(0, 1, 0, 0, 0, 16'h0A7F);
        lit("clamp", running, 16'h0959);
        lit("clamp_state", 16'(state), 16'h0);

        // Borrow chain
        step(0, 1, 0, 0, 0, 16'h1000);
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        lit("borrow_1000", running, 16'h0959);
        step(0, 1, 0, 0, 0, 16'h0100);
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        lit("borrow_0100", running, 16'h0059);

        // Expiry
        step(0, 1, 0, 0, 0, 16'h0002);
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        lit("exp_1", running, 16'h0001);
        step(0, 0, 0, 0, 1, 16'h0);
        lit("exp_0", running, 16'h0);
        lit("exp_flags", {12'h0, state, expired, done_pulse}, 16'h000F);
        step(0, 0, 0, 0, 1, 16'h0);
        lit("exp_pulse_drop", {12'h0, state, expired, done_pulse}, 16'h000E);
        step(0, 0, 1, 0, 1, 16'h0);
        lit("done_hold", running, 16'h0);
        step(0, 1, 0, 0, 0, 16'h0030);
        lit("done_load", {running[11:0], 2'b0, state}, {12'h030, 4'h0});

        // Pause / resume
        step(0, 1, 0, 0, 0, 16'h0106);
        step(0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        step(0, 0, 0, 1, 1, 16'h0);
        lit("pause", running, 16'h0105);
        lit("pause_state", 16'(state), 16'h2);
        step(0, 0, 0, 0, 1, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        lit("pause_hold", running, 16'h0105);
        step(0, 0, 1, 0, 1, 16'h0);
        lit("resume", {running[11:0], 2'b0, state}, {12'h105, 4'h1});
        step(0, 0, 0, 0, 1, 16'h0);
        lit("resume_tick", running, 16'h0104);

        // Zero start and load-over-start
        step(0, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 0, 16'h0);
        lit("zero_start", {14'h0, state}, 16'h3);
        lit("zero_pulse", 16'(done_pulse), 16'h1);
        step(0, 0, 0, 0, 0, 16'h0);
        lit("zero_pulse_drop", 16'(done_pulse), 16'h0);
        step(0, 1, 1, 0, 0, 16'h0045);
        lit("load_wins", {running[11:0], 2'b0, state}, {12'h045, 4'h0});

        // Reset discards the expiry pulse
        step(0, 1, 0, 0, 0, 16'h0001);
        step(0, 0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 1, 16'h0);
        lit("rst_kills_pulse", {12'h0, state, expired, done_pulse}, 16'h0);

        // Long run: 2:05 minus 100 ticks, with a few idle gaps
        step(0, 1, 0, 0, 0, 16'h0205);
        step(0, 0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 100; i++) begin
            if (i % 17 == 5) step(0, 0, 0, 0, 0, 16'h0);
            step(0, 0, 0, 0, 1, 16'h0);
        end
        lit("long_run", running, 16'h0025);

        step(0, 0, 0, 0, 0, 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
